vga_out_dither: RTL and testbench

VGA_OUT_DITHER -- requirements
Module: vga_out_dither

---
 rtl/cheshire_hyperbus_pkg.sv | 26 ++
 rtl/vga_dither_chan.sv | 60 ++++++
 rtl/vga_out_dither.sv | 150 +++++++++++++++
 tb/tb_vga_out_dither.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/cheshire_hyperbus_pkg.sv
// =============================================================================
// cheshire_hyperbus_pkg : VGA pin widths and the 4x4 ordered-dither matrix
// Revision: 1.0
// =============================================================================
`default_nettype none

package cheshire_hyperbus_pkg;

   localparam int unsigned VgaOutRedWidth   = 3;
   localparam int unsigned VgaOutGreenWidth = 3;
   localparam int unsigned VgaOutBlueWidth  = 2;

   localparam logic [3:0] Bayer [0:3][0:3] = '{
      '{4'd0,  4'd8,  4'd2,  4'd10},
      '{4'd12, 4'd4,  4'd14, 4'd6 },
      '{4'd3,  4'd11, 4'd1,  4'd9 },
      '{4'd15, 4'd7,  4'd13, 4'd5 }
   };

   function automatic logic [3:0] bayer_lookup(input logic [1:0] row, input logic [1:0] col);
      return Bayer[row][col];
   endfunction

endpackage

`default_nettype wire

// File: rtl/vga_dither_chan.sv
// =============================================================================
// vga_dither_chan : one colour channel -- add threshold offset, saturate,
// truncate to pin width, register on valid pixels.
// Revision: 1.0
// =============================================================================
`default_nettype none

module vga_dither_chan #(
   parameter int unsigned InW  = 5,
   parameter int unsigned OutW = 3
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            valid_i,
   input  logic            dither_en_i,
   input  logic [3:0]      thresh_i,
   input  logic [InW-1:0]  chan_i,
   output logic [OutW-1:0] chan_o
);

   localparam int Diff     = int'(InW) - int'(OutW);
   localparam int ShiftOut = (Diff > 0) ? Diff : 0;
   localparam int ShiftT   = (Diff > 0 && Diff <= 4) ? (4 - Diff) : 4;

   if (Diff < 0 || Diff > 4) begin : g_width_check
      $error("vga_dither_chan: input width minus output width must be 0..4");
   end

   logic [InW:0]    offset;
   logic [InW:0]    sum;
   logic [InW-1:0]  sat;
   logic [OutW-1:0] chan_d, chan_q;

   // The offset is always below 2**Diff, so it fits in InW+1 bits.
   always_comb begin
      offset = '0;
      if (dither_en_i && (Diff > 0)) begin
         offset = (InW+1)'(thresh_i >> ShiftT);
      end
      sum    = {1'b0, chan_i} + offset;
      sat    = sum[InW] ? '1 : sum[InW-1:0];
      chan_d = chan_q;
      if (valid_i) begin
         chan_d = OutW'(sat >> ShiftOut);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         chan_q <= '0;
      end else begin
         chan_q <= chan_d;
      end
   end

   assign chan_o = chan_q;

endmodule

`default_nettype wire

// File: rtl/vga_out_dither.sv
// =============================================================================
// vga_out_dither : ordered-dither RGB reduction to VGA pin widths with
// 1-stage sync delay. Define VGA_DITHER_TEMPORAL_EN for frame-rotated dither.
// Revision: 1.0
// =============================================================================
`default_nettype none

module vga_out_dither
   import cheshire_hyperbus_pkg::*;
#(
   parameter int unsigned InRedW        = 5,
   parameter int unsigned InGreenW      = 6,
   parameter int unsigned InBlueW       = 5,
   parameter int unsigned OutRedW       = VgaOutRedWidth,
   parameter int unsigned OutGreenW     = VgaOutGreenWidth,
   parameter int unsigned OutBlueW      = VgaOutBlueWidth,
   parameter bit          SyncActiveLow = 1'b1
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 pix_valid_i,
   input  logic                 dither_en_i,
   input  logic                 hsync_i,
   input  logic                 vsync_i,
   input  logic [InRedW-1:0]    red_i,
   input  logic [InGreenW-1:0]  green_i,
   input  logic [InBlueW-1:0]   blue_i,
   output logic                 hsync_o,
   output logic                 vsync_o,
   output logic [OutRedW-1:0]   red_o,
   output logic [OutGreenW-1:0] green_o,
   output logic [OutBlueW-1:0]  blue_o
);

   localparam logic SyncIdle = SyncActiveLow ? 1'b1 : 1'b0;

   logic       hs_act, vs_act, hs_edge, vs_edge;
   logic       hs_act_q, hs_act_d, vs_act_q, vs_act_d;
   logic       hsync_q, hsync_d, vsync_q, vsync_d;
   logic [1:0] col_q, col_d, row_q, row_d;
   logic [1:0] bayer_col;
   logic [3:0] thresh;

   assign hs_act  = hsync_i ^ SyncActiveLow;
   assign vs_act  = vsync_i ^ SyncActiveLow;
   assign hs_edge = pix_valid_i & hs_act & ~hs_act_q;
   assign vs_edge = pix_valid_i & vs_act & ~vs_act_q;

   // A clear always wins over an increment in the same pixel.
   always_comb begin
      hs_act_d = hs_act_q;
      vs_act_d = vs_act_q;
      hsync_d  = hsync_q;
      vsync_d  = vsync_q;
      col_d    = col_q;
      row_d    = row_q;
      if (pix_valid_i) begin
         hs_act_d = hs_act;
         vs_act_d = vs_act;
         hsync_d  = hsync_i;
         vsync_d  = vsync_i;
         col_d    = hs_edge ? 2'd0 : col_q + 2'd1;
         if (vs_edge) begin
            row_d = 2'd0;
         end else if (hs_edge) begin
            row_d = row_q + 2'd1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         hs_act_q <= 1'b0;
         vs_act_q <= 1'b0;
         hsync_q  <= SyncIdle;
         vsync_q  <= SyncIdle;
         col_q    <= 2'd0;
         row_q    <= 2'd0;
      end else begin
         hs_act_q <= hs_act_d;
         vs_act_q <= vs_act_d;
         hsync_q  <= hsync_d;
         vsync_q  <= vsync_d;
         col_q    <= col_d;
         row_q    <= row_d;
      end
   end

`ifdef VGA_DITHER_TEMPORAL_EN
   logic [1:0] frame_q, frame_d;

   always_comb begin
      frame_d = frame_q;
      if (vs_edge) begin
         frame_d = frame_q + 2'd1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         frame_q <= 2'd0;
      end else begin
         frame_q <= frame_d;
      end
   end

   // Rotating the column per frame shifts the pattern so it averages over time.
   assign bayer_col = col_q + frame_q;
`else
   assign bayer_col = col_q;
`endif

   assign thresh = bayer_lookup(row_q, bayer_col);

   vga_dither_chan #(.InW(InRedW), .OutW(OutRedW)) u_chan_red (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .valid_i     (pix_valid_i),
      .dither_en_i (dither_en_i),
      .thresh_i    (thresh),
      .chan_i      (red_i),
      .chan_o      (red_o)
   );

   vga_dither_chan #(.InW(InGreenW), .OutW(OutGreenW)) u_chan_green (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .valid_i     (pix_valid_i),
      .dither_en_i (dither_en_i),
      .thresh_i    (thresh),
      .chan_i      (green_i),
      .chan_o      (green_o)
   );

   vga_dither_chan #(.InW(InBlueW), .OutW(OutBlueW)) u_chan_blue (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .valid_i     (pix_valid_i),
      .dither_en_i (dither_en_i),
      .thresh_i    (thresh),
      .chan_i      (blue_i),
      .chan_o      (blue_o)
   );

   assign hsync_o = hsync_q;
   assign vsync_o = vsync_q;

endmodule

`default_nettype wire

// File: tb/tb_vga_out_dither.sv
// =============================================================================
// tb_vga_out_dither : scoreboard bench for vga_out_dither (default widths,
// active-low syncs); directed corner pixels followed by random traffic.
// Revision: 1.0
// =============================================================================
`default_nettype none

module tb_vga_out_dither;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       pix_valid, dither_en, hsync, vsync;
   logic [4:0] red;
   logic [5:0] green;
   logic [4:0] blue;
   logic       hsync_o, vsync_o;
   logic [2:0] red_o, green_o;
   logic [1:0] blue_o;

   always #5 clk = ~clk;

   vga_out_dither dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .pix_valid_i (pix_valid),
      .dither_en_i (dither_en),
      .hsync_i     (hsync),
      .vsync_i     (vsync),
      .red_i       (red),
      .green_i     (green),
      .blue_i      (blue),
      .hsync_o     (hsync_o),
      .vsync_o     (vsync_o),
      .red_o       (red_o),
      .green_o     (green_o),
      .blue_o      (blue_o)
   );

   typedef struct packed {
      logic [2:0] r;
      logic [2:0] g;
      logic [1:0] b;
      logic       hs;
      logic       vs;
   } exp_t;

   exp_t exp_q[$];
   exp_t last_exp;
   int   total = 0;
   int   bad   = 0;

   // Reference model state: position in the dither tile and sync history.
   int bayer [4][4] = '{'{0, 8, 2, 10}, '{12, 4, 14, 6}, '{3, 11, 1, 9}, '{15, 7, 13, 5}};
   int col_m, row_m, frame_m;
   bit hs_prev, vs_prev;

   function automatic int chan_model(int in_val, int in_w, int out_w, int t, bit de);
      int d, off, s, max_v;
      d     = in_w - out_w;
      off   = (de && d > 0) ? (t >> (4 - d)) : 0;
      max_v = (1 << in_w) - 1;
      s     = in_val + off;
      if (s > max_v) s = max_v;
      return s >> d;
   endfunction

   task automatic model_reset();
      col_m = 0; row_m = 0; frame_m = 0;
      hs_prev = 1'b0; vs_prev = 1'b0;
   endtask

   task automatic drive(input bit v, input bit hs, input bit vs, input int r, input int g,
                        input int b, input bit de, input bit lit = 1'b0,
                        input int lr = 0, input int lg = 0, input int lb = 0);
      exp_t e;
      int   t;
      bit   hs_e, vs_e;
      @(negedge clk);
      pix_valid = v; hsync = hs; vsync = vs; dither_en = de;
      red = 5'(r); green = 6'(g); blue = 5'(b);
      if (v) begin
         t    = bayer[row_m][(col_m + frame_m) % 4];
         e.r  = lit ? 3'(lr) : 3'(chan_model(r, 5, 3, t, de));
         e.g  = lit ? 3'(lg) : 3'(chan_model(g, 6, 3, t, de));
         e.b  = lit ? 2'(lb) : 2'(chan_model(b, 5, 2, t, de));
         e.hs = hs;
         e.vs = vs;
         exp_q.push_back(e);
         hs_e  = !hs && !hs_prev;
         vs_e  = !vs && !vs_prev;
         col_m = hs_e ? 0 : (col_m + 1) % 4;
         row_m = vs_e ? 0 : (hs_e ? (row_m + 1) % 4 : row_m);
`ifdef VGA_DITHER_TEMPORAL_EN
         if (vs_e) frame_m = (frame_m + 1) % 4;
`endif
         hs_prev = !hs;
         vs_prev = !vs;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      pix_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      total++;
      if (red_o !== 3'd0 || green_o !== 3'd0 || blue_o !== 2'd0 || hsync_o !== 1'b1 || vsync_o !== 1'b1) begin
         bad++;
         $display("FAIL async_reset: got r=%0d g=%0d b=%0d hs=%0b vs=%0b, want 0 0 0 1 1",
                  red_o, green_o, blue_o, hsync_o, vsync_o);
      end
      exp_q.delete();
      last_exp = '{r: 3'd0, g: 3'd0, b: 2'd0, hs: 1'b1, vs: 1'b1};
      model_reset();
      hsync = 1'b1; vsync = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Monitor: every accepted pixel produces one output one valid cycle later;
   // between valid pixels the outputs must hold.
   initial begin
      bit   fire;
      exp_t e;
      forever begin
         @(posedge clk);
         fire = pix_valid && rst_n;
         #1;
         if (!rst_n) continue;
         if (fire) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL pixel_unexpected: output update with empty scoreboard");
            end else begin
               e = exp_q.pop_front();
               last_exp = e;
               if ({red_o, green_o, blue_o, hsync_o, vsync_o} !== e) begin
                  bad++;
                  $display("FAIL pixel: got r=%0d g=%0d b=%0d hs=%0b vs=%0b, want r=%0d g=%0d b=%0d hs=%0b vs=%0b",
                           red_o, green_o, blue_o, hsync_o, vsync_o, e.r, e.g, e.b, e.hs, e.vs);
               end
            end
         end else begin
            total++;
            if ({red_o, green_o, blue_o, hsync_o, vsync_o} !== last_exp) begin
               bad++;
               $display("FAIL hold: got r=%0d g=%0d b=%0d hs=%0b vs=%0b, want r=%0d g=%0d b=%0d hs=%0b vs=%0b",
                        red_o, green_o, blue_o, hsync_o, vsync_o,
                        last_exp.r, last_exp.g, last_exp.b, last_exp.hs, last_exp.vs);
            end
         end
      end
   end

   initial begin
      bit hs_s, vs_s;
      int rows_red [5] = '{6, 5, 6, 5, 6};
      rst_n = 1'b0; pix_valid = 1'b0; dither_en = 1'b0;
      hsync = 1'b1; vsync = 1'b1; red = '0; green = '0; blue = '0;
      do_reset();

      // Truncation, then dithered pixels on row 0.
      drive(1, 1, 1, 22, 20, 9, 0, 1, 5, 2, 1);
      drive(1, 1, 1, 22, 20, 9, 1, 1, 6, 3, 1);
      drive(0, 1, 1, 0, 0, 0, 0);
      drive(1, 1, 1, 22, 20, 9, 0, 1, 5, 2, 1);

      // Hsync edge, then five pixels on row 1 walk columns 0,1,2,3,0.
      drive(1, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0);
      foreach (rows_red[i]) drive(1, 1, 1, 22, 0, 0, 1, 1, rows_red[i], 0, 0);

      // Coincident hsync and vsync edges return to row 0, column 0.
      drive(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
`ifdef VGA_DITHER_TEMPORAL_EN
      drive(1, 1, 1, 22, 0, 0, 1, 1, 6, 0, 0);
      drive(1, 1, 1, 22, 0, 0, 1, 1, 5, 0, 0);
`else
      drive(1, 1, 1, 22, 0, 0, 1, 1, 5, 0, 0);
      drive(1, 1, 1, 22, 0, 0, 1, 1, 6, 0, 0);
`endif

      // Three line edges reach row 3; full-scale input must saturate.
      repeat (2) begin
         drive(1, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0);
         drive(1, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0);
      end
      drive(1, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0);
      drive(1, 1, 1, 31, 63, 31, 1, 1, 7, 7, 3);

      // Random traffic against the model, with one reset in the middle.
      hs_s = 1'b1; vs_s = 1'b1;
      for (int i = 0; i < 1500; i++) begin
         if (i == 700) begin
            do_reset();
            hs_s = 1'b1; vs_s = 1'b1;
         end
         if ($urandom_range(0, 7) == 0) hs_s = ~hs_s;
         if ($urandom_range(0, 31) == 0) vs_s = ~vs_s;
         drive($urandom_range(0, 3) != 0, hs_s, vs_s,
               ($urandom_range(0, 3) == 0) ? 31 : int'($urandom_range(0, 31)),
               ($urandom_range(0, 3) == 0) ? 63 : int'($urandom_range(0, 63)),
               ($urandom_range(0, 3) == 0) ? 31 : int'($urandom_range(0, 31)),
               $urandom_range(0, 1) == 1);
      end
      drive(0, hs_s, vs_s, 0, 0, 0, 0);

      for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain: %0d pixels still pending, want 0", exp_q.size());
      end
      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
